// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, BOOT/RUN/HALTED control and the IF/ID pipeline register.
// Every output comes straight from a flop; imem_data only feeds flop inputs.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instr_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        addr_err,
    output logic        halted,
    output logic [31:0] fetch_count
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_next;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   instr_next;
    logic [XLEN-1:0]   pc_plus4_next;
    logic [XLEN-1:0]   count_next;
    logic              valid_next;
    logic              err_next;
    logic              load_bubble;
    logic              load_fetch;

    assign pc_plus4  = pc + XLEN'(4);
    assign imem_addr = pc;

    // State, PC and IF/ID registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BOOT;
            pc          <= RESET_PC;
            instr_d     <= NOP_INSTR;
            pc_plus4_d  <= '0;
            valid_d     <= 1'b0;
            addr_err    <= 1'b0;
            halted      <= 1'b0;
            fetch_count <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr_d     <= instr_next;
            pc_plus4_d  <= pc_plus4_next;
            valid_d     <= valid_next;
            addr_err    <= err_next;
            halted      <= (state_next == HALTED);
            fetch_count <= count_next;
        end
    end

    // Next state, next PC and IF/ID load decision
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        err_next      = addr_err;
        load_bubble   = 1'b0;
        load_fetch    = 1'b0;
        instr_next    = instr_d;
        pc_plus4_next = pc_plus4_d;
        valid_next    = valid_d;
        count_next    = fetch_count;

        case (state)
            BOOT: begin
                state_next  = RUN;
                load_bubble = 1'b1;
            end
            RUN: begin
                if (halt) begin
                    state_next  = HALTED;
                    load_bubble = 1'b1;
                end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
                    state_next  = HALTED;
                    err_next    = 1'b1;
                    load_bubble = 1'b1;
                end else begin
                    if (redirect) begin
                        pc_next = redirect_pc;
                    end else if (!stall) begin
                        pc_next = pc_plus4;
                    end
                    // A redirect alone still captures this fetch; flush squashes it.
                    if (flush) begin
                        load_bubble = 1'b1;
                    end else if (!stall) begin
                        load_fetch = 1'b1;
                    end
                end
            end
            HALTED: begin
                state_next = HALTED;
            end
            default: begin
                state_next  = BOOT;
                load_bubble = 1'b1;
            end
        endcase

        if (load_bubble) begin
            instr_next    = NOP_INSTR;
            pc_plus4_next = '0;
            valid_next    = 1'b0;
        end else if (load_fetch) begin
            instr_next    = imem_data;
            pc_plus4_next = pc_plus4;
            valid_next    = 1'b1;
            count_next    = fetch_count + XLEN'(1);
        end
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, meaning: first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000, meaning: instruction word inserted as a bubble.
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 stall  input  1  hazard hold: freeze PC and IF/ID register.
REQ-006 flush  input  1  load a bubble into IF/ID.
REQ-007 redirect  input  1  taken branch or jump from downstream.
REQ-008 redirect_pc  input  32  branch or jump target.
REQ-009 halt  input  1  syscall-exit decoded downstream.
REQ-010 imem_addr  output  32  fetch address (PCF) to combinational instruction memory.
REQ-011 imem_data  input  32  instruction word returned for imem_addr in the same cycle.
REQ-012 instr_d  output  32  IF/ID instruction.
REQ-013 pc_plus4_d  output  32  IF/ID PC+4 of instr_d.
REQ-014 valid_d  output  1  IF/ID holds a real instruction.
REQ-015 addr_err  output  1  sticky misaligned-redirect flag.
REQ-016 halted  output  1  fetch permanently stopped.
REQ-017 fetch_count  output  32  count of instructions delivered to IF/ID.

Function
REQ-018 The block SHALL implement states BOOT, RUN and HALTED.
REQ-019 In every state, imem_addr SHALL equal the PC register; the PC register holds a word-aligned value at all times.
REQ-020 BOOT SHALL last exactly one cycle after reset deasserts and SHALL load IF/ID with a bubble; in BOOT the PC holds RESET_PC and stall, flush, redirect and halt are ignored; the next state is RUN.
REQ-021 In RUN, the next-PC priority SHALL be: halt, then redirect, then stall, then PC+4, with all arithmetic modulo 2^32.
REQ-022 In RUN with halt=1, the block SHALL enter HALTED, hold the PC and load a bubble into IF/ID.
REQ-023 In RUN with redirect=1 and redirect_pc[1:0]==0, the PC SHALL load redirect_pc on the next edge, even when stall=1.
REQ-024 In RUN with redirect=1 and redirect_pc[1:0]!=0, the block SHALL set addr_err, enter HALTED, hold the PC and load a bubble into IF/ID.
REQ-025 In RUN with stall=1 and no redirect, the PC SHALL hold its value.
REQ-026 For the IF/ID register in RUN, flush=1 SHALL load a bubble, taking priority over stall.
REQ-027 For the IF/ID register in RUN, stall=1 with flush=0 SHALL hold IF/ID unchanged.
REQ-028 For the IF/ID register in RUN, the default SHALL load instr_d=imem_data, pc_plus4_d=PC+4 and valid_d=1.
REQ-029 A bubble SHALL be defined as instr_d=NOP_INSTR, pc_plus4_d=0 and valid_d=0.
REQ-030 Redirect without flush SHALL still capture the current fetch; squashing that fetch is the caller's duty, done by asserting flush.
REQ-031 The block SHALL leave HALTED only through reset; in HALTED the PC and IF/ID are frozen, and stall, flush, redirect and halt are ignored.
REQ-032 halted SHALL be 1 exactly when the state is HALTED.
REQ-033 fetch_count SHALL increment by 1 on each edge where IF/ID loads with valid_d=1, and SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-034 The block SHALL have no combinational path from any input to any output except imem_data to nothing, meaning every output is registered.

Reset
REQ-035 On reset, the block SHALL set state=BOOT, PC=RESET_PC, instr_d=NOP_INSTR, pc_plus4_d=0, valid_d=0, addr_err=0, halted=0 and fetch_count=0.
REQ-036 Reset asserted mid-operation, including in HALTED, SHALL take priority over all other inputs on that edge.

Verification
REQ-037 Reset then free run with imem_data=32'h2008_0005 -> cycle 1 after reset: valid_d=0; cycle 2: instr_d=32'h2008_0005, pc_plus4_d=32'h0040_0004; imem_addr steps 0x00400000, 0x00400004, 0x00400008.
REQ-038 Stall for 3 cycles at PC=0x00400008 -> imem_addr and IF/ID are unchanged for 3 cycles and fetch_count does not increment; the PC resumes at 0x0040000C.
REQ-039 Redirect with redirect_pc=0x00400100, flush=1 and stall=1 in the same cycle -> next cycle: imem_addr=0x00400100 and valid_d=0; the cycle after: pc_plus4_d=0x00400104.
REQ-040 Redirect with redirect_pc=0x00400102 -> addr_err=1, halted=1, PC held, valid_d=0; later redirect and flush inputs change nothing.
REQ-041 Halt in RUN, then reset pulse -> halted=1 until reset; after reset, fetch_count=0 and imem_addr=0x00400000.
REQ-042 Preload fetch_count near wrap via 2^32-1 delivered fetches (or a forced value in simulation) -> the next valid load gives fetch_count=0.
